adder_result_streamer: RTL and testbench

Readout side of the 32-bit adder datapath. Captures one adder result (sum plus carry-out) on a load strobe and emits it least-significant byte first over an 8-bit valid/ready stream, for a byte-oriented consumer such as a UART transmitter or a display sequencer. It is the counterpart of the byte-wise operand loader: that block assembles words from bytes, and this one breaks the result word back into bytes. Only one result is in flight at a time.

---
 rtl/adder_result_streamer_if.sv | 25 ++
 rtl/adder_result_streamer.sv | 127 ++++++++++++
 tb/tb_adder_result_streamer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_result_streamer_if.sv
// Byte stream from the adder result streamer to a byte-oriented consumer.
// master drives the beat, slave returns out_ready.
interface adder_result_streamer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [2:0] out_idx;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    output out_idx,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    input  out_idx,
    output out_ready
  );
endinterface

// File: rtl/adder_result_streamer.sv
// Captures one adder result (sum + carry) on load and streams it LSB byte first,
// optionally followed by a carry beat, over an 8-bit valid/ready interface.
module adder_result_streamer #(
  parameter int NBYTES     = 4,
  parameter int SEND_CARRY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [8*NBYTES-1:0]     sum,
  input  logic                    carry,
  adder_result_streamer_if.master stream,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam int         BEATS    = NBYTES + SEND_CARRY;
  localparam logic [2:0] LAST_IDX = 3'(BEATS - 1);

  state_t              state, state_n;
  logic [8*NBYTES-1:0] hold_sum, hold_sum_n;
  logic                hold_carry, hold_carry_n;
  logic [7:0]          data_q, data_n;
  logic                valid_q, valid_n;
  logic                last_q, last_n;
  logic [2:0]          idx_q, idx_n;
  logic                busy_n, overrun_n;
  logic [2:0]          idx_inc;
  logic [7:0]          next_byte;
  logic                xfer;

  assign idx_inc = idx_q + 3'd1;
  assign xfer    = valid_q & stream.out_ready;

  // Byte that becomes visible once the current beat has been accepted.
  always_comb begin
    next_byte = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx_inc == 3'(k)) next_byte = hold_sum[8*k +: 8];
    end
    if (SEND_CARRY != 0 && idx_inc == 3'(NBYTES)) next_byte = {7'b0, hold_carry};
  end

  always_comb begin
    state_n      = state;
    hold_sum_n   = hold_sum;
    hold_carry_n = hold_carry;
    data_n       = data_q;
    valid_n      = valid_q;
    last_n       = last_q;
    idx_n        = idx_q;
    busy_n       = busy;
    overrun_n    = overrun;
    case (state)
      IDLE: begin
        if (load) begin
          state_n      = SEND;
          hold_sum_n   = sum;
          hold_carry_n = carry;
          data_n       = sum[7:0];
          valid_n      = 1'b1;
          last_n       = (LAST_IDX == 3'd0);
          idx_n        = 3'd0;
          busy_n       = 1'b1;
        end
      end
      SEND: begin
        if (xfer && last_q) begin
          if (load) begin
            // New result follows the final beat with no bubble.
            hold_sum_n   = sum;
            hold_carry_n = carry;
            data_n       = sum[7:0];
            last_n       = (LAST_IDX == 3'd0);
            idx_n        = 3'd0;
          end else begin
            state_n = IDLE;
            data_n  = 8'h00;
            valid_n = 1'b0;
            last_n  = 1'b0;
            idx_n   = 3'd0;
            busy_n  = 1'b0;
          end
        end else begin
          if (xfer) begin
            idx_n  = idx_inc;
            data_n = next_byte;
            last_n = (idx_inc == LAST_IDX);
          end
          if (load) overrun_n = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_sum   <= '0;
      hold_carry <= 1'b0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      idx_q      <= 3'd0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      hold_sum   <= hold_sum_n;
      hold_carry <= hold_carry_n;
      data_q     <= data_n;
      valid_q    <= valid_n;
      last_q     <= last_n;
      idx_q      <= idx_n;
      busy       <= busy_n;
      overrun    <= overrun_n;
    end
  end

  assign stream.out_data  = data_q;
  assign stream.out_valid = valid_q;
  assign stream.out_last  = last_q;
  assign stream.out_idx   = idx_q;

endmodule

// File: tb/tb_adder_result_streamer.sv
// Scoreboard bench for adder_result_streamer: a carry-beat build and a sum-only build.
module tb_adder_result_streamer;
  logic        clk = 1'b0;
  logic        rst, load, carry, load2, carry2;
  logic [31:0] sum, sum2;
  logic        busy, overrun, busy2, overrun2;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] idx;
    logic       last;
  } beat_t;

  beat_t q[$];
  beat_t q2[$];
  int    checks = 0;
  int    failures = 0;

  adder_result_streamer_if s1();
  adder_result_streamer_if s2();

  adder_result_streamer #(.NBYTES(4), .SEND_CARRY(1)) dut (
    .clk(clk), .rst(rst), .load(load), .sum(sum), .carry(carry),
    .stream(s1), .busy(busy), .overrun(overrun)
  );

  adder_result_streamer #(.NBYTES(4), .SEND_CARRY(0)) dut_nc (
    .clk(clk), .rst(rst), .load(load2), .sum(sum2), .carry(carry2),
    .stream(s2), .busy(busy2), .overrun(overrun2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic push_result(input logic [31:0] s, input logic c, input int beats, input bit second);
    beat_t b;
    for (int k = 0; k < beats; k++) begin
      b.data = (k < 4) ? s[8*k +: 8] : {7'b0, c};
      b.idx  = 3'(k);
      b.last = (k == beats - 1);
      if (second) q2.push_back(b);
      else        q.push_back(b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; load2 = 1'b0; sum = '0; sum2 = '0; carry = 1'b0; carry2 = 1'b0;
    s1.out_ready = 1'b1; s2.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({s1.out_data, s1.out_valid, s1.out_last, s1.out_idx, busy, overrun} !== 15'h0) begin
      failures++;
      $display("FAIL reset_state got d=%h v=%b l=%b i=%0d busy=%b ovr=%b exp all zero",
               s1.out_data, s1.out_valid, s1.out_last, s1.out_idx, busy, overrun);
    end
    checks++;
    if ({s2.out_data, s2.out_valid, s2.out_last, s2.out_idx, busy2, overrun2} !== 15'h0) begin
      failures++;
      $display("FAIL reset_state_nc got d=%h v=%b busy=%b exp all zero", s2.out_data, s2.out_valid, busy2);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    beat_t exp;
    @(negedge clk);
    load = 1'b1; sum = 32'h12345678; carry = 1'b1; s1.out_ready = 1'b1;
    push_result(32'h12345678, 1'b1, 5, 1'b0);
    cyc = 0;
    while (q.size() > 0 && cyc < 20) begin
      @(negedge clk); load = 1'b0; cyc++;
      exp = q[0];
      checks++;
      if (!s1.out_valid || !busy || {s1.out_data, s1.out_idx, s1.out_last} !== exp) begin
        failures++;
        $display("FAIL basic_beat got v=%b busy=%b d=%h i=%0d l=%b exp d=%h i=%0d l=%b",
                 s1.out_valid, busy, s1.out_data, s1.out_idx, s1.out_last, exp.data, exp.idx, exp.last);
      end
      void'(q.pop_front());
    end
    checks++;
    if (cyc != 5) begin failures++; $display("FAIL basic_cycles got=%0d exp=5", cyc); end
    @(negedge clk);
    checks++;
    if ({s1.out_valid, busy, s1.out_last, s1.out_data} !== 11'h0) begin
      failures++;
      $display("FAIL basic_idle got v=%b busy=%b l=%b d=%h exp 0", s1.out_valid, busy, s1.out_last, s1.out_data);
    end
  endtask

  task automatic test_backpressure();
    int cyc, stalls;
    beat_t exp;
    @(negedge clk);
    load = 1'b1; sum = 32'h12345678; carry = 1'b1; s1.out_ready = 1'b1;
    push_result(32'h12345678, 1'b1, 5, 1'b0);
    cyc = 0; stalls = 0;
    while (q.size() > 0 && cyc < 30) begin
      @(negedge clk); load = 1'b0; cyc++;
      exp = q[0];
      checks++;
      if (!s1.out_valid || {s1.out_data, s1.out_idx, s1.out_last} !== exp) begin
        failures++;
        $display("FAIL bp_beat got v=%b d=%h i=%0d l=%b exp d=%h i=%0d l=%b stalls=%0d",
                 s1.out_valid, s1.out_data, s1.out_idx, s1.out_last, exp.data, exp.idx, exp.last, stalls);
      end
      if (exp.idx == 3'd2 && stalls < 3) begin
        s1.out_ready = 1'b0; stalls++;
      end else begin
        s1.out_ready = 1'b1;
        void'(q.pop_front());
      end
    end
    s1.out_ready = 1'b1;
    checks++;
    if (cyc != 8) begin failures++; $display("FAIL bp_cycles got=%0d exp=8", cyc); end
    @(negedge clk);
    checks++;
    if (s1.out_valid !== 1'b0) begin failures++; $display("FAIL bp_extra_beat got v=1 exp v=0"); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit reloaded;
    beat_t exp;
    @(negedge clk);
    load = 1'b1; sum = 32'hFFFFFFFF; carry = 1'b0; s1.out_ready = 1'b1;
    push_result(32'hFFFFFFFF, 1'b0, 5, 1'b0);
    cyc = 0; reloaded = 1'b0;
    while (q.size() > 0 && cyc < 30) begin
      @(negedge clk); load = 1'b0; cyc++;
      exp = q[0];
      checks++;
      if (!s1.out_valid || {s1.out_data, s1.out_idx, s1.out_last} !== exp) begin
        failures++;
        $display("FAIL b2b_beat cyc=%0d got v=%b d=%h i=%0d l=%b exp d=%h i=%0d l=%b",
                 cyc, s1.out_valid, s1.out_data, s1.out_idx, s1.out_last, exp.data, exp.idx, exp.last);
      end
      void'(q.pop_front());
      if (!reloaded && cyc == 5) begin
        load = 1'b1; sum = 32'h00000001; carry = 1'b1;
        push_result(32'h00000001, 1'b1, 5, 1'b0);
        reloaded = 1'b1;
      end
    end
    checks++;
    if (cyc != 10) begin failures++; $display("FAIL b2b_cycles got=%0d exp=10", cyc); end
    @(negedge clk);
    checks++;
    if ({s1.out_valid, busy, overrun} !== 3'b000) begin
      failures++;
      $display("FAIL b2b_end got v=%b busy=%b ovr=%b exp 000", s1.out_valid, busy, overrun);
    end
  endtask

  task automatic test_overrun();
    int cyc;
    bit pulsed, exp_ovr;
    beat_t exp;
    @(negedge clk);
    load = 1'b1; sum = 32'hAABBCCDD; carry = 1'b0; s1.out_ready = 1'b1;
    push_result(32'hAABBCCDD, 1'b0, 5, 1'b0);
    cyc = 0; pulsed = 1'b0; exp_ovr = 1'b0;
    while (q.size() > 0 && cyc < 20) begin
      @(negedge clk); load = 1'b0; cyc++;
      exp = q[0];
      checks++;
      if (!s1.out_valid || {s1.out_data, s1.out_idx, s1.out_last} !== exp) begin
        failures++;
        $display("FAIL ovr_beat got v=%b d=%h i=%0d l=%b exp d=%h i=%0d l=%b",
                 s1.out_valid, s1.out_data, s1.out_idx, s1.out_last, exp.data, exp.idx, exp.last);
      end
      checks++;
      if (overrun !== exp_ovr) begin
        failures++;
        $display("FAIL ovr_flag cyc=%0d got=%b exp=%b", cyc, overrun, exp_ovr);
      end
      void'(q.pop_front());
      if (!pulsed && exp.idx == 3'd1) begin
        load = 1'b1; sum = 32'h11111111; carry = 1'b1; pulsed = 1'b1;
      end
      exp_ovr = pulsed;
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({s1.out_valid, busy, overrun} !== 3'b001) begin
        failures++;
        $display("FAIL ovr_after got v=%b busy=%b ovr=%b exp v=0 busy=0 ovr=1", s1.out_valid, busy, overrun);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int cyc;
    beat_t exp;
    @(negedge clk);
    load = 1'b1; sum = 32'hCAFEF00D; carry = 1'b0; s1.out_ready = 1'b1;
    push_result(32'hCAFEF00D, 1'b0, 5, 1'b0);
    cyc = 0;
    while (q.size() > 2 && cyc < 20) begin
      @(negedge clk); load = 1'b0; cyc++;
      exp = q[0];
      checks++;
      if (!s1.out_valid || {s1.out_data, s1.out_idx, s1.out_last} !== exp) begin
        failures++;
        $display("FAIL rstm_beat got v=%b d=%h i=%0d exp d=%h i=%0d",
                 s1.out_valid, s1.out_data, s1.out_idx, exp.data, exp.idx);
      end
      void'(q.pop_front());
    end
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({s1.out_data, s1.out_valid, s1.out_last, s1.out_idx, busy, overrun} !== 15'h0) begin
      failures++;
      $display("FAIL rstm_state got d=%h v=%b l=%b i=%0d busy=%b ovr=%b exp all zero",
               s1.out_data, s1.out_valid, s1.out_last, s1.out_idx, busy, overrun);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (s1.out_valid !== 1'b0) begin failures++; $display("FAIL rstm_leftover got v=1 d=%h exp v=0", s1.out_data); end
    end
    load = 1'b1; sum = 32'h0; carry = 1'b0;
    push_result(32'h0, 1'b0, 5, 1'b0);
    cyc = 0;
    while (q.size() > 0 && cyc < 20) begin
      @(negedge clk); load = 1'b0; cyc++;
      exp = q[0];
      checks++;
      if (!s1.out_valid || {s1.out_data, s1.out_idx, s1.out_last} !== exp) begin
        failures++;
        $display("FAIL rstm_reload got v=%b d=%h i=%0d l=%b exp d=%h i=%0d l=%b",
                 s1.out_valid, s1.out_data, s1.out_idx, s1.out_last, exp.data, exp.idx, exp.last);
      end
      void'(q.pop_front());
    end
    checks++;
    if (cyc != 5) begin failures++; $display("FAIL rstm_reload_cycles got=%0d exp=5", cyc); end
  endtask

  task automatic test_no_carry();
    int cyc;
    beat_t exp;
    @(negedge clk);
    load2 = 1'b1; sum2 = 32'h01020304; carry2 = 1'b1; s2.out_ready = 1'b1;
    push_result(32'h01020304, 1'b1, 4, 1'b1);
    cyc = 0;
    while (q2.size() > 0 && cyc < 20) begin
      @(negedge clk); load2 = 1'b0; cyc++;
      exp = q2[0];
      checks++;
      if (!s2.out_valid || !busy2 || {s2.out_data, s2.out_idx, s2.out_last} !== exp) begin
        failures++;
        $display("FAIL nc_beat got v=%b d=%h i=%0d l=%b exp d=%h i=%0d l=%b",
                 s2.out_valid, s2.out_data, s2.out_idx, s2.out_last, exp.data, exp.idx, exp.last);
      end
      void'(q2.pop_front());
    end
    checks++;
    if (cyc != 4) begin failures++; $display("FAIL nc_cycles got=%0d exp=4", cyc); end
    @(negedge clk);
    checks++;
    if ({s2.out_valid, busy2, s2.out_data} !== 10'h0) begin
      failures++;
      $display("FAIL nc_idle got v=%b busy=%b d=%h exp 0", s2.out_valid, busy2, s2.out_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_overrun();
    test_reset_midstream();
    test_no_carry();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
